// File: rtl/pc_fetch_unit_if.sv
// Purpose: bundles the fetch-stage control, interrupt and PC/return-address signals.
// Latency: none; this is wiring only.
// Backpressure: stall is the only hold signal; it is driven by the core side.
// Ports:
//   core side (master) drives stall, branch/jump/jr controls, illegal_op and the irq lines.
//   fetch side (slave) drives pc, pc_plus4, xp_we, xp_data, kernel and cause.
interface pc_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic        illegal_op;
  logic        irq_timer;
  logic        irq_utx;
  logic        irq_urx;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        xp_we;
  logic [31:0] xp_data;
  logic        kernel;
  logic [2:0]  cause;

  modport master (
    output stall, branch_taken, branch_imm, jump, jump_target, jr, jr_addr,
           illegal_op, irq_timer, irq_utx, irq_urx,
    input  pc, pc_plus4, xp_we, xp_data, kernel, cause
  );

  modport slave (
    input  stall, branch_taken, branch_imm, jump, jump_target, jr, jr_addr,
           illegal_op, irq_timer, irq_utx, irq_urx,
    output pc, pc_plus4, xp_we, xp_data, kernel, cause
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Purpose: PC register and next-PC select with exception/IRQ vectoring and kernel-mode tracking.
// Latency: the chosen next PC appears on pc one clock later; xp_we/xp_data/cause are combinational.
// Backpressure: stall holds pc, kernel and cause and suppresses events; pending IRQs still latch.
// Ports:
//   clk, reset (synchronous, active-low)
//   fbus (slave): next-PC controls, illegal_op, irq_* in; pc, pc_plus4, xp_we, xp_data, kernel, cause out.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] VEC_TIMER = 32'h0000_0004,
  parameter logic [31:0] VEC_EXC   = 32'h0000_0008,
  parameter logic [31:0] VEC_UTX   = 32'h0000_000C,
  parameter logic [31:0] VEC_URX   = 32'h0000_0010
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.slave  fbus
);

  localparam logic [2:0] CAUSE_TIMER = 3'd1;
  localparam logic [2:0] CAUSE_EXC   = 3'd2;
  localparam logic [2:0] CAUSE_UTX   = 3'd3;
  localparam logic [2:0] CAUSE_URX   = 3'd4;

  // Pending bit order: [0] timer, [1] utx, [2] urx.
  logic [31:0] pc_q;
  logic        kernel_q;
  logic [2:0]  pend_q;
  logic [2:0]  cause_q;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] nx;
  logic [31:0] pc_d;
  logic [2:0]  irq_in;
  logic [2:0]  pend_eff;
  logic [2:0]  take_mask;
  logic [2:0]  pend_d;
  logic [2:0]  ev_cause;
  logic [2:0]  cause_d;
  logic        take_exc;
  logic        take_irq;
  logic        ev_we;
  logic        kernel_d;
  logic [31:0] ev_data;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{fbus.branch_imm[15]}}, fbus.branch_imm, 2'b00};

    if (fbus.jr) begin
      nx = fbus.jr_addr & 32'hFFFF_FFFC;
    end else if (fbus.jump) begin
      nx = {pc_plus4[31:28], fbus.jump_target, 2'b00};
    end else if (fbus.branch_taken) begin
      nx = pc_plus4 + br_off;
    end else begin
      nx = pc_plus4;
    end

    // Same-cycle requests count as pending so a pulse is never missed.
    irq_in   = {fbus.irq_urx, fbus.irq_utx, fbus.irq_timer};
    pend_eff = pend_q | irq_in;

    // Events use the registered kernel flag, so handlers never nest.
    take_exc = !fbus.stall && !kernel_q && fbus.illegal_op;
    take_irq = !fbus.stall && !kernel_q && !fbus.illegal_op && (|pend_eff);

    take_mask = 3'b000;
    ev_cause  = 3'd0;
    pc_d      = nx;
    if (take_exc) begin
      ev_cause = CAUSE_EXC;
      pc_d     = VEC_EXC;
    end else if (take_irq) begin
      if (pend_eff[0]) begin
        take_mask = 3'b001;
        ev_cause  = CAUSE_TIMER;
        pc_d      = VEC_TIMER;
      end else if (pend_eff[2]) begin
        take_mask = 3'b100;
        ev_cause  = CAUSE_URX;
        pc_d      = VEC_URX;
      end else begin
        take_mask = 3'b010;
        ev_cause  = CAUSE_UTX;
        pc_d      = VEC_UTX;
      end
    end
    if (fbus.stall) begin
      pc_d = pc_q;
    end

    ev_we = take_exc || take_irq;
    // An exception skips the faulting instruction; an interrupt lets it complete.
    ev_data = take_exc ? pc_plus4 : nx;

    pend_d = pend_eff & ~take_mask;

    kernel_d = kernel_q;
    if (!fbus.stall) begin
      if (ev_we) begin
        kernel_d = 1'b1;
      end else if (fbus.jr && kernel_q) begin
        kernel_d = 1'b0;
      end
    end

    cause_d = ev_we ? ev_cause : cause_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      kernel_q <= 1'b1;
      pend_q   <= 3'b000;
      cause_q  <= 3'd0;
    end else begin
      pc_q     <= {pc_d[31:2], 2'b00};
      kernel_q <= kernel_d;
      pend_q   <= pend_d;
      cause_q  <= cause_d;
    end
  end

  assign fbus.pc       = pc_q;
  assign fbus.pc_plus4 = pc_plus4;
  assign fbus.xp_we    = ev_we;
  assign fbus.xp_data  = ev_data;
  assign fbus.kernel   = kernel_q;
  assign fbus.cause    = cause_d;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose: scoreboard bench for pc_fetch_unit; directed walk-through then random traffic.
// Latency: expectations are queued per cycle and checked on the falling edge of that cycle.
// Backpressure: stall is randomised alongside the other controls.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] imm;
    logic        jump;
    logic [25:0] tgt;
    logic        jr;
    logic [31:0] jra;
    logic        ill;
    logic        it;
    logic        iu;
    logic        ir;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        kern;
    logic        we;
    logic [31:0] data;
    logic [2:0]  cause;
    logic        chk_cause;
    logic        hv;
    logic [31:0] h_pc;
    logic        h_we;
    logic [31:0] h_data;
    logic [2:0]  h_cause;
  } exp_t;

  logic clk;
  logic reset;
  pc_fetch_unit_if bus();

  pc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .fbus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: the architectural view of the fetch unit.
  logic [31:0] m_pc;
  bit          m_kern;
  bit          m_pt, m_pu, m_pr;
  bit          m_just_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("pc_plus4", bus.pc_plus4, e.pc4);
      chk("kernel", {31'd0, bus.kernel}, {31'd0, e.kern});
      chk("xp_we", {31'd0, bus.xp_we}, {31'd0, e.we});
      if (e.we) begin
        chk("xp_data", bus.xp_data, e.data);
      end
      if (e.chk_cause) begin
        chk("cause", {29'd0, bus.cause}, {29'd0, e.cause});
      end
      if (e.hv) begin
        chk("dir_pc", bus.pc, e.h_pc);
        chk("dir_xp_we", {31'd0, bus.xp_we}, {31'd0, e.h_we});
        if (e.h_we) begin
          chk("dir_xp_data", bus.xp_data, e.h_data);
          chk("dir_cause", {29'd0, bus.cause}, {29'd0, e.h_cause});
        end
      end
    end
  end

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // One clock of stimulus: drive, queue the expected response, advance the model.
  task automatic step(input stim_t s, input bit hv = 1'b0, input logic [31:0] hpc = 32'd0,
                      input bit hwe = 1'b0, input logic [31:0] hdat = 32'd0,
                      input logic [2:0] hc = 3'd0);
    exp_t        e;
    logic [31:0] pc4, nx, new_pc;
    bit          pt, pu, pr, new_k;
    int          off;
    @(posedge clk);
    #1;
    reset            = !s.rst;
    bus.stall        = s.stall;
    bus.branch_taken = s.br;
    bus.branch_imm   = s.imm;
    bus.jump         = s.jump;
    bus.jump_target  = s.tgt;
    bus.jr           = s.jr;
    bus.jr_addr      = s.jra;
    bus.illegal_op   = s.ill;
    bus.irq_timer    = s.it;
    bus.irq_utx      = s.iu;
    bus.irq_urx      = s.ir;
    if (s.rst) begin
      m_pc = 32'h0; m_kern = 1'b1; m_pt = 0; m_pu = 0; m_pr = 0; m_just_rst = 1'b1;
      return;
    end
    pc4 = m_pc + 32'd4;
    off = $signed(s.imm);
    if (s.jr)        nx = s.jra & ~32'h3;
    else if (s.jump) nx = {pc4[31:28], s.tgt, 2'b00};
    else if (s.br)   nx = pc4 + 32'(off * 4);
    else             nx = pc4;
    pt = m_pt | s.it; pu = m_pu | s.iu; pr = m_pr | s.ir;
    e = '0;
    e.pc = m_pc; e.pc4 = pc4; e.kern = m_kern;
    new_pc = nx; new_k = m_kern;
    if (s.stall) begin
      new_pc = m_pc;
    end else if (!m_kern && s.ill) begin
      e.we = 1; e.data = pc4; e.cause = 3'd2; new_pc = 32'h8; new_k = 1;
    end else if (!m_kern && (pt || pu || pr)) begin
      e.we = 1; e.data = nx; new_k = 1;
      if (pt)      begin e.cause = 3'd1; new_pc = 32'h4;  pt = 0; end
      else if (pr) begin e.cause = 3'd4; new_pc = 32'h10; pr = 0; end
      else         begin e.cause = 3'd3; new_pc = 32'hC;  pu = 0; end
    end else if (s.jr && m_kern) begin
      new_k = 0;
    end
    e.chk_cause = e.we || m_just_rst;
    e.hv = hv; e.h_pc = hpc; e.h_we = hwe; e.h_data = hdat; e.h_cause = hc;
    exp_q.push_back(e);
    m_pc = new_pc; m_kern = new_k; m_pt = pt; m_pu = pu; m_pr = pr; m_just_rst = 1'b0;
  endtask

  initial begin
    stim_t s;
    reset = 1'b0;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_imm = '0; bus.jump = 0;
    bus.jump_target = '0; bus.jr = 0; bus.jr_addr = '0; bus.illegal_op = 0;
    bus.irq_timer = 0; bus.irq_utx = 0; bus.irq_urx = 0;
    m_pc = 0; m_kern = 1; m_pt = 0; m_pu = 0; m_pr = 0; m_just_rst = 1;

    // Directed walk-through with hand-computed PCs and events.
    s = nop(); s.rst = 1; step(s); step(s);
    s = nop(); step(s, 1, 32'h0); step(s, 1, 32'h4); step(s, 1, 32'h8);
    s = nop(); s.jump = 1; s.tgt = 26'h85; step(s, 1, 32'hC);
    s = nop(); s.jr = 1; s.jra = 32'h258; step(s, 1, 32'h214);
    s = nop(); step(s, 1, 32'h258); step(s, 1, 32'h25C);
    s = nop(); s.br = 1; s.imm = 16'hFFFE; step(s, 1, 32'h260);
    s = nop(); s.jump = 1; s.tgt = 26'h0C0; step(s, 1, 32'h25C);
    s.it = 1; step(s, 1, 32'h300, 1, 32'h300, 3'd1);
    s = nop(); s.ir = 1; step(s, 1, 32'h4);
    s = nop(); s.iu = 1; step(s, 1, 32'h8);
    s = nop(); s.jr = 1; s.jra = 32'h304; step(s, 1, 32'hC);
    s = nop(); step(s, 1, 32'h304, 1, 32'h308, 3'd4);
    s = nop(); s.jr = 1; s.jra = 32'h308; step(s, 1, 32'h10);
    s = nop(); step(s, 1, 32'h308, 1, 32'h30C, 3'd3);
    s = nop(); s.jr = 1; s.jra = 32'h30C; step(s, 1, 32'hC);
    s = nop(); s.jump = 1; s.tgt = 26'h100; step(s, 1, 32'h30C);
    s = nop(); s.ill = 1; s.it = 1; step(s, 1, 32'h400, 1, 32'h404, 3'd2);
    s = nop(); s.jr = 1; s.jra = 32'h404; step(s, 1, 32'h8);
    s = nop(); step(s, 1, 32'h404, 1, 32'h408, 3'd1);
    s = nop(); s.jr = 1; s.jra = 32'h408; step(s, 1, 32'h4);
    s = nop(); s.stall = 1; s.iu = 1; step(s, 1, 32'h408);
    s.iu = 0; step(s, 1, 32'h408);
    s.iu = 1; step(s, 1, 32'h408);
    s = nop(); step(s, 1, 32'h408, 1, 32'h40C, 3'd3);
    s = nop(); s.it = 1; step(s, 1, 32'hC);
    s = nop(); s.rst = 1; s.it = 1; step(s);
    s = nop(); step(s, 1, 32'h0);
    s = nop(); s.jr = 1; s.jra = 32'h502; step(s, 1, 32'h4);
    s = nop(); step(s, 1, 32'h500); step(s, 1, 32'h504);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      s = nop();
      s.rst   = ($urandom_range(0, 299) == 0);
      s.stall = ($urandom_range(0, 7) == 0);
      s.br    = ($urandom_range(0, 5) == 0);
      s.imm   = 16'($urandom);
      s.jump  = ($urandom_range(0, 9) == 0);
      s.tgt   = 26'($urandom);
      s.jr    = ($urandom_range(0, 7) == 0);
      s.jra   = $urandom;
      s.ill   = ($urandom_range(0, 15) == 0);
      s.it    = ($urandom_range(0, 19) == 0);
      s.iu    = ($urandom_range(0, 11) == 0);
      s.ir    = ($urandom_range(0, 11) == 0);
      step(s);
    end

    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage that drives the instruction ROM address in the single-cycle MIPS core.
- Each cycle it selects the next PC from sequential, branch, jump, jump-register and the fixed handler vectors: 0x0 reset, 0x4 timer, 0x8 exception, 0xC UART-send, 0x10 UART-receive.
- It latches peripheral interrupt requests, arbitrates them, supplies the return address for $26, and tracks kernel mode so handlers run unnested until their closing jr.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- VEC_TIMER, 32'h0000_0004, timer interrupt vector.
- VEC_EXC, 32'h0000_0008, exception vector.
- VEC_UTX, 32'h0000_000C, UART-send interrupt vector.
- VEC_URX, 32'h0000_0010, UART-receive interrupt vector.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hold PC; no state changes except pending-IRQ capture.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_imm  in  16  branch offset in words, sign-extended.
- jump  in  1  j/jal this cycle.
- jump_target  in  26  instr[25:0].
- jr  in  1  jr/jalr this cycle.
- jr_addr  in  32  rs register value.
- illegal_op  in  1  current instruction is undefined (synchronous exception).
- irq_timer  in  1  timer interrupt pulse/level.
- irq_utx  in  1  UART-send done pulse/level.
- irq_urx  in  1  UART-receive done pulse/level.
- pc  out  32  current PC; drives ROM addr.
- pc_plus4  out  32  pc+4 (jal link value).
- xp_we  out  1  write $26 this cycle.
- xp_data  out  32  return address for $26.
- kernel  out  1  kernel-mode flag.
- cause  out  3  0 none, 1 timer, 2 exception, 3 utx, 4 urx; valid when xp_we=1.

Behaviour:
- Reset (reset=0 at a clk edge): pc=RESET_PC, kernel=1, pending=000, xp_we=0, cause=0. Reset has priority over all inputs, including mid-handler.
- Sequential next-PC, nx, priority high to low:
  - jr: nx = jr_addr.
  - jump: nx = {pc_plus4[31:28], jump_target, 2'b00}.
  - branch_taken: nx = pc_plus4 + (sext(branch_imm) << 2), with 32-bit wrap.
  - otherwise: nx = pc_plus4.
- Pending register, one bit per source:
  - Set on any cycle its irq input is 1, including during stall and kernel mode.
  - Cleared only when that source is taken. A bit set and taken in the same cycle ends cleared.
- Event selection, evaluated only when stall=0, using the registered kernel flag. Priority:
  - illegal_op and kernel=0: pc <= VEC_EXC, xp_data = pc_plus4 (skips the offending instruction), cause=2.
  - Else, any pending bit (or same-cycle irq input) and kernel=0: take the highest of timer > urx > utx. pc <= its vector, xp_data = nx (the current instruction completes; no instruction is lost), cause = 1/4/3.
  - Else: pc <= nx.
- On taking an event: xp_we=1 (combinational, same cycle), kernel <= 1, and that pending bit clears. Other pending bits are retained.
- illegal_op while kernel=1: ignored and no vector taken; execution continues to nx.
- Leaving kernel mode: a jr executed while kernel=1 sets kernel <= 0. This covers both handler return (jr $26) and the boot jump to main. A pending IRQ is therefore taken no earlier than the cycle after the jr, i.e. at the first user instruction. That instruction completes, so forward progress is guaranteed.
- Stall=1: pc, kernel and cause are held; xp_we=0; no event is taken.
- pc[1:0] is always 00. jr_addr[1:0] is forced to 00.
- Latency: the selected next PC appears on pc one clock after the decision. xp_we/xp_data are combinational in the decision cycle.

Test Plan:
- Reset, then 3 free clocks: pc = 0x0, 0x4, 0x8; kernel=1; xp_we never 1.
- At pc=0x214, jr with jr_addr=0x258 in kernel: next pc=0x258, kernel=0. Then branch_taken with imm=0xFFFE at pc=0x260: next pc=0x25C.
- kernel=0, pc=0x300, irq_timer 1-cycle pulse alongside jump_target=0x0C0: xp_we=1, xp_data=0x300, cause=1, next pc=0x4, kernel=1.
- In kernel, pulse irq_urx then irq_utx: no vector taken. After jr to 0x304: one instruction at 0x304 executes, then vector 0x10 (cause 4, xp_data=0x308). After its return jr, next user instruction then vector 0xC (cause 3).
- kernel=0, illegal_op and irq_timer together at pc=0x400: vector 0x8, xp_data=0x404, cause=2. Timer stays pending and is taken after the handler's jr.
- stall=1 for 3 cycles with irq_utx pulsing in user mode: pc held, xp_we=0. On stall release, vector 0xC taken. Assert reset=0 mid-handler: pc=0x0, kernel=1, pending=0.
